// File: rtl/ica_cordic_pkg.sv
// Shared types and bundle layout for the ICA CORDIC channel arbiter.
// Bundle fields are packed LSB-first in the order listed below.
package ica_cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_OWN
    } state_t;

    localparam int OFF_VEC_EN  = 0;
    localparam int OFF_VEC_XIN = 1;

    function automatic int req_bus_w(input int dw, input int cs);
        return 4 * dw + cs + 6;
    endfunction

    function automatic int off_vec_yin(input int dw);
        return 1 + dw;
    endfunction

    function automatic int off_angle_calc_en(input int dw);
        return 1 + 2 * dw;
    endfunction

    function automatic int off_rot1_en(input int dw);
        return 2 + 2 * dw;
    endfunction

    function automatic int off_rot1_xin(input int dw);
        return 3 + 2 * dw;
    endfunction

    function automatic int off_rot1_yin(input int dw);
        return 3 + 3 * dw;
    endfunction

    function automatic int off_micro_rot(input int dw);
        return 3 + 4 * dw;
    endfunction

    function automatic int off_quad(input int dw, input int cs);
        return 3 + 4 * dw + cs;
    endfunction

    function automatic int off_angle_micro_rot_n(input int dw, input int cs);
        return 4 + 4 * dw + cs;
    endfunction

    function automatic int off_micro_rot_ext_vld(input int dw, input int cs);
        return 5 + 4 * dw + cs;
    endfunction

endpackage

// File: rtl/ica_cordic_arbiter_rr_pick.sv
// Round-robin first-one finder: lowest-distance request at or after ptr.
// Purely combinational; result is one-hot or zero.
module ica_cordic_arbiter_rr_pick #(
    parameter int NUM_REQ = 3,
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] pick
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ica_cordic_arbiter.sv
// Lock-until-release round-robin arbiter sharing one CORDIC wrapper channel.
// The wrapper is held in reset whenever no requester owns it.
module ica_cordic_arbiter
    import ica_cordic_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int DATA_WIDTH    = 32,
    parameter int CORDIC_STAGES = 16,
    parameter int FLUSH_CYCLES  = 2,
    parameter int TIMEOUT       = 1024,
    localparam int REQ_BUS_W    = req_bus_w(DATA_WIDTH, CORDIC_STAGES),
    localparam int PW           = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           req_release,
    input  logic [NUM_REQ*REQ_BUS_W-1:0] req_bus,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           gnt_ready,
    output logic [REQ_BUS_W-1:0]         cordic_bus,
    output logic                         cordic_nrst,
    input  logic                         cordic_vec_opvld,
    input  logic                         cordic_rot1_opvld,
    output logic [NUM_REQ-1:0]           req_vec_opvld,
    output logic [NUM_REQ-1:0]           req_rot1_opvld,
    output logic                         timeout_err
);

    localparam int FW        = $clog2(FLUSH_CYCLES + 1);
    localparam int WW        = $clog2(TIMEOUT) + 1;
    localparam int ROT1_EN_O = off_rot1_en(DATA_WIDTH);

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt, pick;
    logic [PW-1:0]      rr_ptr, rr_ptr_nxt, owner;
    logic [FW-1:0]      flush_cnt, flush_cnt_nxt;
    logic [WW-1:0]      wdog, wdog_nxt;
    logic               own, owner_req, owner_rel, active, wd_hit;

    ica_cordic_arbiter_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_pick (
        .req (req),
        .ptr (rr_ptr),
        .pick(pick)
    );

    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) owner = PW'(i);
        end
    end

    assign own = (state == ST_OWN);

    // Non-owner slices never reach the wrapper; bus idles at zero.
    always_comb begin
        cordic_bus = '0;
        if (own) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i]) cordic_bus = req_bus[i*REQ_BUS_W +: REQ_BUS_W];
            end
        end
    end

    assign owner_req = |(req & gnt);
    assign owner_rel = |(req_release & gnt);
    assign active    = cordic_bus[OFF_VEC_EN] | cordic_bus[ROT1_EN_O]
                     | cordic_vec_opvld | cordic_rot1_opvld;
    assign wd_hit    = own && (wdog == WW'(TIMEOUT));

    assign gnt_ready      = own ? gnt : '0;
    assign cordic_nrst    = own;
    assign timeout_err    = wd_hit;
    assign req_vec_opvld  = gnt & {NUM_REQ{cordic_vec_opvld}};
    assign req_rot1_opvld = gnt & {NUM_REQ{cordic_rot1_opvld}};

    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        rr_ptr_nxt    = rr_ptr;
        flush_cnt_nxt = flush_cnt;
        wdog_nxt      = '0;
        unique case (state)
            ST_IDLE: begin
                if (|req) begin
                    gnt_nxt       = pick;
                    flush_cnt_nxt = '0;
                    state_nxt     = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == FW'(FLUSH_CYCLES - 1)) begin
                    state_nxt = ST_OWN;
                end else begin
                    flush_cnt_nxt = flush_cnt + 1'b1;
                end
            end
            ST_OWN: begin
                if (owner_rel || !owner_req || wd_hit) begin
                    state_nxt  = ST_IDLE;
                    gnt_nxt    = '0;
                    rr_ptr_nxt = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                end else begin
                    wdog_nxt = active ? '0 : wdog + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            flush_cnt <= '0;
            wdog      <= '0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            rr_ptr    <= rr_ptr_nxt;
            flush_cnt <= flush_cnt_nxt;
            wdog      <= wdog_nxt;
        end
    end

endmodule
